pipeline_ctrl: RTL and testbench

- Central stall/flush/valid controller for the 5-stage RV32I pipeline (IF, ID, EX, MEM, WB).
- Generates the per-register load enables and the per-stage valid bits.
- Runs a fetch FSM that discards wrong-path instruction responses after a redirect.
- Parametrised for register-index width, forwarding mode and performance-counter width; adds memory-response stalls, load-use/RAW interlock, branch flush and saturating perf counters.

---
 rtl/pipeline_ctrl_if.sv | 58 +++++
 rtl/pipeline_ctrl.sv | 164 ++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_if.sv
// Handshake and hazard bundle between the pipeline datapath and its controller.
//   master : the controller (pipeline_ctrl). It takes the memory handshakes and
//            hazard sources, and drives the enables, valids and counters.
//   slave  : the datapath / memory side. It takes the enables, valids and counters.
interface pipeline_ctrl_if #(
    parameter int unsigned REG_IDX_W = 5,
    parameter int unsigned CNT_W     = 32
);
    // memory handshakes and redirect
    logic                 inst_resp;
    logic                 data_access;
    logic                 data_resp;
    logic                 branch_taken;
    // hazard sources
    logic [REG_IDX_W-1:0] id_rs1;
    logic [REG_IDX_W-1:0] id_rs2;
    logic                 id_use_rs1;
    logic                 id_use_rs2;
    logic [REG_IDX_W-1:0] ex_rd;
    logic [REG_IDX_W-1:0] mem_rd;
    logic [REG_IDX_W-1:0] wb_rd;
    logic                 ex_regwrite;
    logic                 mem_regwrite;
    logic                 wb_regwrite;
    logic                 ex_is_load;
    // controls
    logic                 inst_read;
    logic                 pc_load;
    logic                 ifid_load;
    logic                 idex_load;
    logic                 exmem_load;
    logic                 memwb_load;
    logic                 ifid_valid;
    logic                 idex_valid;
    logic                 exmem_valid;
    logic                 memwb_valid;
    logic [CNT_W-1:0]     stall_cnt;
    logic [CNT_W-1:0]     flush_cnt;
    logic [CNT_W-1:0]     retire_cnt;

    modport master (
        input  inst_resp, data_access, data_resp, branch_taken,
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  ex_rd, mem_rd, wb_rd, ex_regwrite, mem_regwrite, wb_regwrite, ex_is_load,
        output inst_read, pc_load, ifid_load, idex_load, exmem_load, memwb_load,
        output ifid_valid, idex_valid, exmem_valid, memwb_valid,
        output stall_cnt, flush_cnt, retire_cnt
    );

    modport slave (
        output inst_resp, data_access, data_resp, branch_taken,
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output ex_rd, mem_rd, wb_rd, ex_regwrite, mem_regwrite, wb_regwrite, ex_is_load,
        input  inst_read, pc_load, ifid_load, idex_load, exmem_load, memwb_load,
        input  ifid_valid, idex_valid, exmem_valid, memwb_valid,
        input  stall_cnt, flush_cnt, retire_cnt
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush/valid controller for a 5-stage RV32I pipeline.
//   clk, rst : clock and asynchronous active-low reset
//   bus      : pipeline_ctrl_if.master, which carries:
//     - the memory handshakes and redirect (inst_resp, data_access, data_resp, branch_taken)
//     - the hazard sources (ID sources, EX/MEM/WB destinations)
//     - the combinational load enables and inst_read
//     - the registered stage valids and the saturating perf counters
// Priority is mem_stall > redirect > raw > fetch wait > normal flow.
module pipeline_ctrl #(
    parameter int unsigned REG_IDX_W = 5,
    parameter bit          FWD_EN    = 1'b1,
    parameter int unsigned CNT_W     = 32
) (
    input  logic          clk,
    input  logic          rst,
    pipeline_ctrl_if.master bus
);

    typedef enum logic {F_RUN = 1'b0, F_DISCARD = 1'b1} fetch_state_e;

    fetch_state_e     state_q, state_d;
    logic             ifid_v_q, idex_v_q, exmem_v_q, memwb_v_q;
    logic             ifid_v_d, idex_v_d, exmem_v_d, memwb_v_d;
    logic [CNT_W-1:0] stall_q, flush_q, retire_q;

    logic mem_stall, redirect, redirect_act, raw, raw_load, raw_any, fetch_wait;
    logic pc_ld, ifid_ld, idex_ld, exmem_ld, memwb_ld;

    // ID reads a nonzero register produced by a qualified stage
    function automatic logic src_match(
        input logic [REG_IDX_W-1:0] rd,
        input logic                 ok,
        input logic [REG_IDX_W-1:0] rs1,
        input logic [REG_IDX_W-1:0] rs2,
        input logic                 use1,
        input logic                 use2
    );
        return ok && (rd != '0) && ((use1 && (rs1 == rd)) || (use2 && (rs2 == rd)));
    endfunction

    // Hazard terms
    assign mem_stall    = exmem_v_q & bus.data_access & ~bus.data_resp;
    assign redirect     = idex_v_q & bus.branch_taken;
    assign redirect_act = redirect & ~mem_stall;
    assign fetch_wait   = (state_q == F_DISCARD) | ~bus.inst_resp;

    assign raw_load = idex_v_q & bus.ex_is_load &
                      src_match(bus.ex_rd, bus.ex_regwrite, bus.id_rs1, bus.id_rs2,
                                bus.id_use_rs1, bus.id_use_rs2);
    assign raw_any  = src_match(bus.ex_rd, idex_v_q & bus.ex_regwrite, bus.id_rs1, bus.id_rs2,
                                bus.id_use_rs1, bus.id_use_rs2) |
                      src_match(bus.mem_rd, exmem_v_q & bus.mem_regwrite, bus.id_rs1, bus.id_rs2,
                                bus.id_use_rs1, bus.id_use_rs2) |
                      src_match(bus.wb_rd, memwb_v_q & bus.wb_regwrite, bus.id_rs1, bus.id_rs2,
                                bus.id_use_rs1, bus.id_use_rs2);
    // With forwarding only a load in EX needs an interlock
    assign raw = FWD_EN ? raw_load : raw_any;

    // Next-state, load enables and next valids
    always_comb begin
        state_d   = state_q;
        pc_ld     = 1'b0;
        ifid_ld   = 1'b0;
        idex_ld   = 1'b0;
        exmem_ld  = 1'b0;
        memwb_ld  = 1'b0;
        ifid_v_d  = ifid_v_q;
        idex_v_d  = idex_v_q;
        exmem_v_d = exmem_v_q;
        memwb_v_d = memwb_v_q;

        if (rst) begin
            if (mem_stall) begin
                memwb_ld  = 1'b1;
                memwb_v_d = 1'b0;
            end else if (redirect) begin
                pc_ld     = 1'b1;
                ifid_ld   = 1'b1;
                idex_ld   = 1'b1;
                exmem_ld  = 1'b1;
                memwb_ld  = 1'b1;
                ifid_v_d  = 1'b0;
                idex_v_d  = 1'b0;
                exmem_v_d = idex_v_q;
                memwb_v_d = exmem_v_q;
            end else if (raw) begin
                idex_ld   = 1'b1;
                exmem_ld  = 1'b1;
                memwb_ld  = 1'b1;
                idex_v_d  = 1'b0;
                exmem_v_d = idex_v_q;
                memwb_v_d = exmem_v_q;
            end else if (fetch_wait) begin
                ifid_ld   = 1'b1;
                idex_ld   = 1'b1;
                exmem_ld  = 1'b1;
                memwb_ld  = 1'b1;
                ifid_v_d  = 1'b0;
                idex_v_d  = ifid_v_q;
                exmem_v_d = idex_v_q;
                memwb_v_d = exmem_v_q;
            end else begin
                pc_ld     = 1'b1;
                ifid_ld   = 1'b1;
                idex_ld   = 1'b1;
                exmem_ld  = 1'b1;
                memwb_ld  = 1'b1;
                ifid_v_d  = 1'b1;
                idex_v_d  = ifid_v_q;
                exmem_v_d = idex_v_q;
                memwb_v_d = exmem_v_q;
            end

            // A redirect held by mem_stall has not moved the PC, so nothing is in flight to drop
            case (state_q)
                F_RUN: begin
                    if (redirect_act && !bus.inst_resp) state_d = F_DISCARD;
                end
                F_DISCARD: begin
                    if (!redirect_act && bus.inst_resp) state_d = F_RUN;
                end
                default: state_d = F_RUN;
            endcase
        end
    end

    // State, valids and saturating counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= F_RUN;
            ifid_v_q  <= 1'b0;
            idex_v_q  <= 1'b0;
            exmem_v_q <= 1'b0;
            memwb_v_q <= 1'b0;
            stall_q   <= '0;
            flush_q   <= '0;
            retire_q  <= '0;
        end else begin
            state_q   <= state_d;
            ifid_v_q  <= ifid_v_d;
            idex_v_q  <= idex_v_d;
            exmem_v_q <= exmem_v_d;
            memwb_v_q <= memwb_v_d;
            if ((mem_stall || raw || fetch_wait) && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
            if (redirect_act && (flush_q != '1))                      flush_q <= flush_q + CNT_W'(1);
            if (memwb_v_q && memwb_ld && (retire_q != '1))            retire_q <= retire_q + CNT_W'(1);
        end
    end

    assign bus.inst_read   = rst;
    assign bus.pc_load     = pc_ld;
    assign bus.ifid_load   = ifid_ld;
    assign bus.idex_load   = idex_ld;
    assign bus.exmem_load  = exmem_ld;
    assign bus.memwb_load  = memwb_ld;
    assign bus.ifid_valid  = ifid_v_q;
    assign bus.idex_valid  = idex_v_q;
    assign bus.exmem_valid = exmem_v_q;
    assign bus.memwb_valid = memwb_v_q;
    assign bus.stall_cnt   = stall_q;
    assign bus.flush_cnt   = flush_q;
    assign bus.retire_cnt  = retire_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: dut_a (FWD_EN=1, CNT_W=4) and dut_b (FWD_EN=0, CNT_W=8)
// share one stimulus stream and are compared against a stage-occupancy model.
module tb_pipeline_ctrl;

    logic clk;
    logic rst;

    pipeline_ctrl_if #(.REG_IDX_W(5), .CNT_W(4)) if_a ();
    pipeline_ctrl_if #(.REG_IDX_W(5), .CNT_W(8)) if_b ();

    pipeline_ctrl #(.REG_IDX_W(5), .FWD_EN(1'b1), .CNT_W(4)) dut_a (.clk(clk), .rst(rst), .bus(if_a.master));
    pipeline_ctrl #(.REG_IDX_W(5), .FWD_EN(1'b0), .CNT_W(8)) dut_b (.clk(clk), .rst(rst), .bus(if_b.master));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit       inst_resp, data_access, data_resp, branch_taken;
        bit [4:0] rs1, rs2;
        bit       use1, use2;
        bit [4:0] ex_rd, mem_rd, wb_rd;
        bit       ex_rw, mem_rw, wb_rw, ex_ld;
    } in_t;

    // v[0]=IF/ID .. v[3]=MEM/WB occupancy; disc = a wrong-path response is still owed
    typedef struct {
        bit [3:0] v;
        bit       disc;
        int       stall, flush, retire;
    } mdl_t;

    // comb = {inst_read, pc_load, memwb_load, exmem_load, idex_load, ifid_load}
    typedef struct {
        bit [5:0] comb;
        bit [3:0] v;
        int       s, f, r;
    } obs_t;

    typedef struct {
        in_t      x;
        bit       pc;
        bit [3:0] v;
    } rec_t;

    int   checks   = 0;
    int   failures = 0;
    mdl_t m  [2];
    mdl_t nm [2];

    task automatic chk(input string nm_s, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm_s, act, exp_v);
        end
    endtask

    function automatic mdl_t mdl_zero();
        mdl_t z;
        z.v = '0; z.disc = 1'b0; z.stall = 0; z.flush = 0; z.retire = 0;
        return z;
    endfunction

    function automatic int sat(input int a, input bit inc, input int maxc);
        int t;
        t = a + (inc ? 1 : 0);
        return (t > maxc) ? maxc : t;
    endfunction

    function automatic bit reads(input in_t x, input bit [4:0] r);
        return (r != 5'd0) && ((x.use1 && x.rs1 == r) || (x.use2 && x.rs2 == r));
    endfunction

    // Each action is a bubble boundary b: stages above b hold, stage b gets a bubble,
    // stages below b shift. b = -1 means everything advances and IF/ID fills.
    function automatic void eval(input mdl_t cur, input in_t x, input bit fwd, input bit r,
                                 input int maxc, output bit [5:0] comb, output mdl_t n);
        bit ms, rd, raw, fw, kill;
        int b;
        n    = cur;
        comb = '0;
        if (!r) begin
            n = mdl_zero();
            return;
        end
        ms = cur.v[2] && x.data_access && !x.data_resp;
        rd = cur.v[1] && x.branch_taken;
        if (fwd) raw = cur.v[1] && x.ex_ld && x.ex_rw && reads(x, x.ex_rd);
        else     raw = (cur.v[1] && x.ex_rw  && reads(x, x.ex_rd))  ||
                       (cur.v[2] && x.mem_rw && reads(x, x.mem_rd)) ||
                       (cur.v[3] && x.wb_rw  && reads(x, x.wb_rd));
        fw   = cur.disc || !x.inst_resp;
        kill = rd && !ms;
        if (ms)       b = 3;
        else if (rd)  b = -1;
        else if (raw) b = 1;
        else if (fw)  b = 0;
        else          b = -1;
        comb[5] = 1'b1;
        comb[4] = (b < 0);
        for (int s = 0; s < 4; s++) comb[s] = (s >= b);
        if (b > 0)       n.v[0] = cur.v[0];
        else if (b == 0) n.v[0] = 1'b0;
        else             n.v[0] = 1'b1;
        for (int s = 1; s < 4; s++) begin
            if (s < b)       n.v[s] = cur.v[s];
            else if (s == b) n.v[s] = 1'b0;
            else             n.v[s] = cur.v[s-1];
        end
        if (kill) begin
            n.v[0] = 1'b0;
            n.v[1] = 1'b0;
            n.disc = cur.disc || !x.inst_resp;
        end else if (x.inst_resp) begin
            n.disc = 1'b0;
        end
        n.stall  = sat(cur.stall, ms || raw || fw, maxc);
        n.flush  = sat(cur.flush, kill, maxc);
        n.retire = sat(cur.retire, cur.v[3], maxc);
    endfunction

    task automatic drive(input in_t x);
        if_a.inst_resp = x.inst_resp;       if_b.inst_resp = x.inst_resp;
        if_a.data_access = x.data_access;   if_b.data_access = x.data_access;
        if_a.data_resp = x.data_resp;       if_b.data_resp = x.data_resp;
        if_a.branch_taken = x.branch_taken; if_b.branch_taken = x.branch_taken;
        if_a.id_rs1 = x.rs1;                if_b.id_rs1 = x.rs1;
        if_a.id_rs2 = x.rs2;                if_b.id_rs2 = x.rs2;
        if_a.id_use_rs1 = x.use1;           if_b.id_use_rs1 = x.use1;
        if_a.id_use_rs2 = x.use2;           if_b.id_use_rs2 = x.use2;
        if_a.ex_rd = x.ex_rd;               if_b.ex_rd = x.ex_rd;
        if_a.mem_rd = x.mem_rd;             if_b.mem_rd = x.mem_rd;
        if_a.wb_rd = x.wb_rd;               if_b.wb_rd = x.wb_rd;
        if_a.ex_regwrite = x.ex_rw;         if_b.ex_regwrite = x.ex_rw;
        if_a.mem_regwrite = x.mem_rw;       if_b.mem_regwrite = x.mem_rw;
        if_a.wb_regwrite = x.wb_rw;         if_b.wb_regwrite = x.wb_rw;
        if_a.ex_is_load = x.ex_ld;          if_b.ex_is_load = x.ex_ld;
    endtask

    function automatic obs_t obs(input int i);
        obs_t o;
        if (i == 0) begin
            o.comb = {if_a.inst_read, if_a.pc_load, if_a.memwb_load, if_a.exmem_load,
                      if_a.idex_load, if_a.ifid_load};
            o.v = {if_a.memwb_valid, if_a.exmem_valid, if_a.idex_valid, if_a.ifid_valid};
            o.s = int'(if_a.stall_cnt); o.f = int'(if_a.flush_cnt); o.r = int'(if_a.retire_cnt);
        end else begin
            o.comb = {if_b.inst_read, if_b.pc_load, if_b.memwb_load, if_b.exmem_load,
                      if_b.idex_load, if_b.ifid_load};
            o.v = {if_b.memwb_valid, if_b.exmem_valid, if_b.idex_valid, if_b.ifid_valid};
            o.s = int'(if_b.stall_cnt); o.f = int'(if_b.flush_cnt); o.r = int'(if_b.retire_cnt);
        end
        return o;
    endfunction

    // Apply inputs after an edge, compare both DUTs against the model before the next edge
    task automatic pre(input in_t x, input bit r);
        bit [5:0] ec;
        mdl_t     n;
        obs_t     o;
        drive(x);
        rst = r;
        if (!r) begin
            m[0] = mdl_zero();
            m[1] = mdl_zero();
        end
        #2;
        for (int i = 0; i < 2; i++) begin
            eval(m[i], x, (i == 0), r, (i == 0) ? 15 : 255, ec, n);
            nm[i] = n;
            o = obs(i);
            chk($sformatf("dut%0d_comb", i),   int'(o.comb), int'(ec));
            chk($sformatf("dut%0d_valid", i),  int'(o.v),    int'(m[i].v));
            chk($sformatf("dut%0d_stall", i),  o.s, m[i].stall);
            chk($sformatf("dut%0d_flush", i),  o.f, m[i].flush);
            chk($sformatf("dut%0d_retire", i), o.r, m[i].retire);
        end
    endtask

    task automatic post();
        @(posedge clk);
        #1;
        m[0] = nm[0];
        m[1] = nm[1];
    endtask

    function automatic in_t rnd_in();
        in_t x;
        x.inst_resp    = ($urandom_range(0, 3) != 0);
        x.data_access  = ($urandom_range(0, 2) == 0);
        x.data_resp    = ($urandom_range(0, 1) == 1);
        x.branch_taken = ($urandom_range(0, 6) == 0);
        x.rs1    = 5'($urandom_range(0, 3));
        x.rs2    = 5'($urandom_range(0, 3));
        x.use1   = ($urandom_range(0, 1) == 1);
        x.use2   = ($urandom_range(0, 1) == 1);
        x.ex_rd  = 5'($urandom_range(0, 3));
        x.mem_rd = 5'($urandom_range(0, 3));
        x.wb_rd  = 5'($urandom_range(0, 3));
        x.ex_rw  = ($urandom_range(0, 1) == 1);
        x.mem_rw = ($urandom_range(0, 1) == 1);
        x.wb_rw  = ($urandom_range(0, 1) == 1);
        x.ex_ld  = ($urandom_range(0, 1) == 1);
        return x;
    endfunction

    in_t  idle, s, x;
    rec_t tbl [12];

    initial begin
        idle = '{default: 0};
        s = idle;
        s.inst_resp = 1'b1;
        m[0] = mdl_zero();
        m[1] = mdl_zero();

        // reset state
        pre(idle, 1'b0); post();
        pre(idle, 1'b0); post();

        // straight line fill, load-use, rd=0 load, mem stall with held redirect
        for (int i = 0; i < 12; i++) tbl[i].x = s;
        tbl[4].x.ex_ld = 1'b1; tbl[4].x.ex_rw = 1'b1; tbl[4].x.ex_rd = 5'd5;
        tbl[4].x.use1  = 1'b1; tbl[4].x.rs1   = 5'd5;
        tbl[6].x.ex_ld = 1'b1; tbl[6].x.ex_rw = 1'b1; tbl[6].x.ex_rd = 5'd0;
        tbl[6].x.use1  = 1'b1; tbl[6].x.rs1   = 5'd0;
        for (int i = 8; i < 12; i++) begin
            tbl[i].x.data_access  = 1'b1;
            tbl[i].x.branch_taken = 1'b1;
            tbl[i].x.data_resp    = (i == 11);
        end
        tbl[0].pc = 1;  tbl[0].v  = 4'b0001;
        tbl[1].pc = 1;  tbl[1].v  = 4'b0011;
        tbl[2].pc = 1;  tbl[2].v  = 4'b0111;
        tbl[3].pc = 1;  tbl[3].v  = 4'b1111;
        tbl[4].pc = 0;  tbl[4].v  = 4'b1101;
        tbl[5].pc = 1;  tbl[5].v  = 4'b1011;
        tbl[6].pc = 1;  tbl[6].v  = 4'b0111;
        tbl[7].pc = 1;  tbl[7].v  = 4'b1111;
        tbl[8].pc = 0;  tbl[8].v  = 4'b0111;
        tbl[9].pc = 0;  tbl[9].v  = 4'b0111;
        tbl[10].pc = 0; tbl[10].v = 4'b0111;
        tbl[11].pc = 1; tbl[11].v = 4'b1100;
        for (int i = 0; i < 12; i++) begin
            pre(tbl[i].x, 1'b1);
            chk($sformatf("tbl%0d_pc_load", i), int'(if_a.pc_load), int'(tbl[i].pc));
            post();
            chk($sformatf("tbl%0d_valids", i),
                int'({if_a.memwb_valid, if_a.exmem_valid, if_a.idex_valid, if_a.ifid_valid}),
                int'(tbl[i].v));
        end
        chk("tbl_stall_cnt",  int'(if_a.stall_cnt),  4);
        chk("tbl_flush_cnt",  int'(if_a.flush_cnt),  1);
        chk("tbl_retire_cnt", int'(if_a.retire_cnt), 4);

        // redirect with no response: next response dropped, then fetch resumes
        pre(s, 1'b1); post();
        pre(s, 1'b1); post();
        x = idle; x.branch_taken = 1'b1;
        pre(x, 1'b1);
        chk("redir_pc_load", int'(if_a.pc_load), 1);
        post();
        chk("redir_ifid_valid", int'(if_a.ifid_valid), 0);
        pre(s, 1'b1);
        chk("discard_pc_load", int'(if_a.pc_load), 0);
        post();
        chk("discard_ifid_valid", int'(if_a.ifid_valid), 0);
        pre(s, 1'b1);
        chk("resume_pc_load", int'(if_a.pc_load), 1);
        post();
        chk("resume_ifid_valid", int'(if_a.ifid_valid), 1);
        chk("redir_flush_cnt", int'(if_a.flush_cnt), 2);

        // mid-stream reset clears valids and counters without a clock edge
        pre(idle, 1'b0);
        chk("rst_mid_valids_a", int'({if_a.memwb_valid, if_a.exmem_valid, if_a.idex_valid, if_a.ifid_valid}), 0);
        chk("rst_mid_retire_a", int'(if_a.retire_cnt), 0);
        chk("rst_mid_flush_a",  int'(if_a.flush_cnt), 0);
        post();

        // no forwarding: producer in MEM then WB interlocks ID for two cycles
        for (int i = 0; i < 3; i++) begin pre(s, 1'b1); post(); end
        x = s; x.mem_rd = 5'd7; x.mem_rw = 1'b1; x.rs1 = 5'd7; x.use1 = 1'b1;
        pre(x, 1'b1);
        chk("nofwd_mem_pc_load", int'(if_b.pc_load), 0);
        post();
        x = s; x.wb_rd = 5'd7; x.wb_rw = 1'b1; x.rs1 = 5'd7; x.use1 = 1'b1;
        pre(x, 1'b1);
        chk("nofwd_wb_pc_load", int'(if_b.pc_load), 0);
        post();
        pre(s, 1'b1);
        chk("nofwd_clear_pc_load", int'(if_b.pc_load), 1);
        post();
        chk("nofwd_stall_cnt", int'(if_b.stall_cnt), 2);

        // saturation: 20 retirements after fill
        pre(idle, 1'b0); post();
        for (int i = 0; i < 24; i++) begin pre(s, 1'b1); post(); end
        chk("sat_retire_a", int'(if_a.retire_cnt), 15);
        chk("sat_retire_b", int'(if_b.retire_cnt), 20);

        // randomized traffic with occasional resets
        for (int i = 0; i < 2000; i++) begin
            pre(rnd_in(), ($urandom_range(0, 99) != 0));
            post();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
